// File: rtl/iter_ctrl_pkg.sv
// Shared constants and state encoding for the iteration controller.
// Imported by iter_ctrl and anything that decodes its state.
package iter_ctrl_pkg;

    localparam int         CNT_W   = 2;
    localparam logic [2:0] RUN_MAX = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_e;

endpackage

// File: rtl/iter_ctrl.sv
// Iteration controller: loads an external 2-bit counter, steps it
// until carry-out, and flags runs that overstay RUN_MAX cycles.
module iter_ctrl
    import iter_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] init_val,
    input  logic             abort,
    input  logic             cnt_cout,
    output logic             cnt_load,
    output logic [CNT_W-1:0] cnt_load_in,
    output logic             cnt_en,
    output logic             step_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       run_len
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] init_q, init_d;
    logic [2:0]       run_len_q, run_len_d;
    logic             err_q, err_d;

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            init_q    <= '0;
            run_len_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            init_q    <= init_d;
            run_len_q <= run_len_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_d     = state_q;
        init_d      = init_q;
        run_len_d   = run_len_q;
        err_d       = err_q;
        cnt_load    = 1'b0;
        cnt_load_in = '0;
        cnt_en      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    init_d    = init_val;
                    run_len_d = '0;
                    err_d     = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_load    = 1'b1;
                cnt_load_in = init_q;
                busy        = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: begin
                cnt_en    = 1'b1;
                busy      = 1'b1;
                run_len_d = run_len_q + 3'd1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_cout) begin
                    state_d = S_DONE;
                end else if (run_len_q == RUN_MAX - 3'd1) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign step_en = cnt_en;
    assign err     = err_q;
    assign run_len = run_len_q;

endmodule

// File: tb/tb_iter_ctrl.sv
// Directed bench for iter_ctrl with a behavioural 2-bit loadable
// counter (terminal-count look-ahead carry at value 2) on cnt_*.
module tb_iter_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] init_val;
    logic       abort;
    logic       cnt_cout;
    logic       cnt_load;
    logic [1:0] cnt_load_in;
    logic       cnt_en;
    logic       step_en;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] run_len;

    logic [1:0] cq;
    logic       cout_kill;

    int tests = 0;
    int fails = 0;

    iter_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .init_val    (init_val),
        .abort       (abort),
        .cnt_cout    (cnt_cout),
        .cnt_load    (cnt_load),
        .cnt_load_in (cnt_load_in),
        .cnt_en      (cnt_en),
        .step_en     (step_en),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .run_len     (run_len)
    );

    always #5 clk = ~clk;

    // Downstream counter: load wins over enable, shares the reset.
    always_ff @(posedge clk) begin
        if (reset)         cq <= 2'd0;
        else if (cnt_load) cq <= cnt_load_in;
        else if (cnt_en)   cq <= cq + 2'd1;
    end

    assign cnt_cout = !cout_kill && cnt_en && (cq == 2'd2);

    function automatic logic [10:0] ev(
        input logic       ld,
        input logic [1:0] li,
        input logic       en,
        input logic       bs,
        input logic       dn,
        input logic       er,
        input logic [2:0] rl
    );
        return {ld, li, en, en, bs, dn, er, rl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        obs = {cnt_load, cnt_load_in, cnt_en, step_en,
               busy, done, err, run_len};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; init_val = 2'd0;
        abort = 1'b0; cout_kill = 1'b0;
        tick(); tick();
        chk("reset_hold", ev(0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        tick();
        chk("idle_after_reset", ev(0, 0, 0, 0, 0, 0, 0));

        // init 0: 3 RUN cycles
        init_val = 2'd0; start = 1'b1;
        tick(); chk("s1_load", ev(1, 0, 0, 1, 0, 0, 0));
        start = 1'b0; init_val = 2'd3;
        tick(); chk("s1_run1", ev(0, 0, 1, 1, 0, 0, 0));
        tick(); chk("s1_run2", ev(0, 0, 1, 1, 0, 0, 1));
        tick(); chk("s1_run3", ev(0, 0, 1, 1, 0, 0, 2));
        tick(); chk("s1_done", ev(0, 0, 0, 0, 1, 0, 3));
        tick(); chk("s1_idle", ev(0, 0, 0, 0, 0, 0, 3));

        // init 3: wraps, 4 RUN cycles
        init_val = 2'd3; start = 1'b1;
        tick(); chk("s2_load", ev(1, 3, 0, 1, 0, 0, 0));
        start = 1'b0;
        tick(); chk("s2_run1", ev(0, 0, 1, 1, 0, 0, 0));
        tick(); chk("s2_run2", ev(0, 0, 1, 1, 0, 0, 1));
        tick(); chk("s2_run3", ev(0, 0, 1, 1, 0, 0, 2));
        tick(); chk("s2_run4", ev(0, 0, 1, 1, 0, 0, 3));
        tick(); chk("s2_done", ev(0, 0, 0, 0, 1, 0, 4));
        tick(); chk("s2_idle", ev(0, 0, 0, 0, 0, 0, 4));

        // init 2 with start held through DONE
        init_val = 2'd2; start = 1'b1;
        tick(); chk("s3_load", ev(1, 2, 0, 1, 0, 0, 0));
        tick(); chk("s3_run1", ev(0, 0, 1, 1, 0, 0, 0));
        tick(); chk("s3_done", ev(0, 0, 0, 0, 1, 0, 1));
        tick(); chk("s3_idle", ev(0, 0, 0, 0, 0, 0, 1));
        tick(); chk("s3_reload", ev(1, 2, 0, 1, 0, 0, 0));
        start = 1'b0;
        tick(); chk("s3_run1b", ev(0, 0, 1, 1, 0, 0, 0));
        tick(); chk("s3_done_b", ev(0, 0, 0, 0, 1, 0, 1));
        tick(); chk("s3_idle_b", ev(0, 0, 0, 0, 0, 0, 1));

        // abort on 2nd RUN cycle
        init_val = 2'd0; start = 1'b1;
        tick(); chk("s4_load", ev(1, 0, 0, 1, 0, 0, 0));
        start = 1'b0;
        tick(); chk("s4_run1", ev(0, 0, 1, 1, 0, 0, 0));
        tick(); chk("s4_run2", ev(0, 0, 1, 1, 0, 0, 1));
        abort = 1'b1;
        tick(); chk("s4_abort_idle", ev(0, 0, 0, 0, 0, 0, 2));
        abort = 1'b0;
        tick(); chk("s4_idle_hold", ev(0, 0, 0, 0, 0, 0, 2));

        // carry suppressed: overrun to ERR
        cout_kill = 1'b1; init_val = 2'd0; start = 1'b1;
        tick(); chk("s5_load", ev(1, 0, 0, 1, 0, 0, 0));
        start = 1'b0;
        tick(); chk("s5_run1", ev(0, 0, 1, 1, 0, 0, 0));
        tick(); chk("s5_run2", ev(0, 0, 1, 1, 0, 0, 1));
        tick(); chk("s5_run3", ev(0, 0, 1, 1, 0, 0, 2));
        tick(); chk("s5_run4", ev(0, 0, 1, 1, 0, 0, 3));
        tick(); chk("s5_err", ev(0, 0, 0, 0, 0, 1, 4));
        start = 1'b1;
        tick(); chk("s5_err_ign_start", ev(0, 0, 0, 0, 0, 1, 4));
        cout_kill = 1'b0;
        tick(); chk("s5_restart_clr", ev(1, 0, 0, 1, 0, 0, 0));
        start = 1'b0;
        tick(); chk("s5_rerun1", ev(0, 0, 1, 1, 0, 0, 0));
        tick(); chk("s5_rerun2", ev(0, 0, 1, 1, 0, 0, 1));
        tick(); chk("s5_rerun3", ev(0, 0, 1, 1, 0, 0, 2));
        tick(); chk("s5_redone", ev(0, 0, 0, 0, 1, 0, 3));

        // reset mid-RUN, with start held high
        init_val = 2'd1; start = 1'b1;
        tick(); chk("s6_idle", ev(0, 0, 0, 0, 0, 0, 3));
        tick(); chk("s6_load", ev(1, 1, 0, 1, 0, 0, 0));
        tick(); chk("s6_run1", ev(0, 0, 1, 1, 0, 0, 0));
        tick(); chk("s6_run2", ev(0, 0, 1, 1, 0, 0, 1));
        reset = 1'b1; abort = 1'b1;
        tick(); chk("s6_reset", ev(0, 0, 0, 0, 0, 0, 0));
        tick(); chk("s6_reset_hold", ev(0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0; start = 1'b0; abort = 1'b0;

        // reset clears sticky err
        cout_kill = 1'b1; init_val = 2'd0; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        tick(); chk("s7_err", ev(0, 0, 0, 0, 0, 1, 4));
        tick(); chk("s7_err_sticky", ev(0, 0, 0, 0, 0, 1, 4));
        reset = 1'b1;
        tick(); chk("s7_reset_clr", ev(0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0; cout_kill = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iter_ctrl.md
ITER_CTRL -- requirements
Module: iter_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: start  in  1  run request, sampled only in IDLE.
REQ-004 SHALL have: init_val  in  2  counter start value, captured when start is accepted.
REQ-005 SHALL have: abort  in  1  cancel request, sampled only in RUN.
REQ-006 SHALL have: cnt_cout  in  1  carry-out from the downstream 2-bit loadable counter.
REQ-007 SHALL have: cnt_load  out  1, cnt_load_in  out  2, cnt_en  out  1  counter controls.
REQ-008 SHALL have: step_en  out  1  datapath step strobe, identical to cnt_en.
REQ-009 SHALL have: busy  out  1, done  out  1 (one-cycle pulse), err  out  1 (sticky), run_len  out  3.

Function
REQ-010 SHALL implement a registered FSM: IDLE=3'd0, LOAD=3'd1, RUN=3'd2, DONE=3'd3, ERR=3'd4; all control outputs decode from state only (Moore).
REQ-011 SHALL, in IDLE with start=1, capture init_val into init_q, clear run_len, clear err, and go to LOAD; start=0 keeps IDLE.
REQ-012 SHALL, in LOAD, drive cnt_load=1, cnt_load_in=init_q, cnt_en=0, busy=1; next state RUN unconditionally.
REQ-013 SHALL, in RUN, drive cnt_en=1, step_en=1, busy=1, cnt_load=0, and increment run_len by 1 each RUN cycle.
REQ-014 SHALL, in RUN, apply priority: abort=1 -> IDLE (no done); else cnt_cout=1 -> DONE; else run_len==3 before the increment -> ERR; else stay in RUN.
REQ-015 SHALL yield a legal step count of ((2 - init_val) mod 4) + 1: init 0->3, 1->2, 2->1, 3->4.
REQ-016 SHALL, in DONE, assert done=1 for exactly one cycle, busy=0, and return to IDLE.
REQ-017 SHALL, in ERR, set err=1 and return to IDLE next cycle; err holds until the next accepted start or reset.
REQ-018 SHALL hold run_len stable outside LOAD/RUN; run_len never exceeds 4.
REQ-019 SHALL ignore start in every state except IDLE, including DONE and ERR.
REQ-020 SHALL drive cnt_load_in=2'b00 in every state except LOAD.

Reset
REQ-021 SHALL, on reset=1 at a clock edge, go to IDLE from any state, including mid-RUN.
REQ-022 SHALL reset all outputs to 0 and clear run_len, init_q, and err.
REQ-023 SHALL give reset priority over start, abort, and cnt_cout.

Structure
REQ-024 SHALL place the state encoding, RUN_MAX=3'd4, and the 2-bit count width constant in shared package iter_ctrl_pkg.
REQ-025 SHALL be a single module with no sub-module; the counter stays external and connects only through the cnt_* ports.

Verification
REQ-026 SHALL use a bench that instantiates the team's 2-bit loadable counter on the cnt_* ports, with its reset tied to the same reset.
REQ-027 Scenario: start=1 with init_val=0 -> LOAD 1 cycle, RUN 3 cycles, done pulse, run_len=3, err=0.
REQ-028 Scenario: init_val=3 -> counter wraps 3->0->1->2, 4 RUN cycles, done=1, run_len=4.
REQ-029 Scenario: init_val=2, with start held high through DONE -> 1 RUN cycle, done, then a second run begins only from IDLE (LOAD two cycles after DONE).
REQ-030 Scenario: abort=1 on the 2nd RUN cycle with init_val=0 -> IDLE next cycle, done never asserts, run_len=2.
REQ-031 Scenario: cnt_cout forced to 0, init_val=0 -> ERR after the 4th RUN cycle, err=1 sticky, next start clears err.
REQ-032 Scenario: reset=1 during RUN -> IDLE next edge, all outputs 0, run_len=0, err=0.
